// File: rtl/z80_bus_responder.sv
// Responding end of the Z80 pin bus: decodes CPU strobes into memory, I/O and
// interrupt-acknowledge transactions, forwards them to a request/ack backend and stretches nWAIT.
module z80_bus_responder #(
  parameter int unsigned MEM_WAIT  = 0,
  parameter int unsigned M1_WAIT   = 0,
  parameter int unsigned IO_WAIT   = 1,
  parameter int unsigned INTA_WAIT = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic        nWAIT,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  int_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_io,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_HOLD, S_DRAIN} state_t;
  typedef enum logic [2:0] {K_MRD, K_FETCH, K_MWR, K_IORD, K_IOWR, K_INTA} kind_t;

  localparam logic [3:0] MEM_W  = MEM_WAIT[3:0];
  localparam logic [3:0] M1_W   = M1_WAIT[3:0];
  localparam logic [3:0] IO_W   = IO_WAIT[3:0];
  localparam logic [3:0] INTA_W = INTA_WAIT[3:0];

  function automatic logic [3:0] wait_for(input kind_t k);
    case (k)
      K_FETCH:        wait_for = M1_W;
      K_IORD, K_IOWR: wait_for = IO_W;
      K_INTA:         wait_for = INTA_W;
      default:        wait_for = MEM_W;
    endcase
  endfunction

  state_t      state, state_nxt;
  kind_t       kind, kind_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_dec;
  logic        ack_seen, ack_seen_nxt;
  logic        nwait_nxt, doe_nxt, req_nxt, we_nxt, io_nxt;
  logic [7:0]  dout_nxt, wdata_nxt;
  logic [15:0] addr_nxt;

  logic        det_valid;
  kind_t       det_kind;
  logic        kind_is_read, drives_bus, strobe_low, bus_released;

  // Strobe decode in priority order; refresh cycles never match a memory kind.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    det_valid = 1'b0;
    det_kind  = K_MRD;
    if (!nIORQ && !nM1) begin
      det_valid = 1'b1;
      det_kind  = K_INTA;
    end else if (!nMREQ && nRFSH && !nRD) begin
      det_valid = 1'b1;
      det_kind  = nM1 ? K_MRD : K_FETCH;
    end else if (!nMREQ && nRFSH && !nWR) begin
      det_valid = 1'b1;
      det_kind  = K_MWR;
    end else if (!nIORQ && nM1 && !nRD) begin
      det_valid = 1'b1;
      det_kind  = K_IORD;
    end else if (!nIORQ && nM1 && !nWR) begin
      det_valid = 1'b1;
      det_kind  = K_IOWR;
    end
  end

  assign kind_is_read = (kind == K_MRD) || (kind == K_FETCH) || (kind == K_IORD);
  assign drives_bus   = kind_is_read || (kind == K_INTA);
  assign strobe_low   = (kind == K_INTA) ? !nIORQ : !nRD;
  assign bus_released = nMREQ && nIORQ;
  assign cnt_dec      = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;

  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    cnt_nxt      = cnt;
    ack_seen_nxt = ack_seen;
    nwait_nxt    = nWAIT;
    dout_nxt     = D_out;
    doe_nxt      = D_oe;
    req_nxt      = 1'b0;
    we_nxt       = mem_we;
    io_nxt       = mem_io;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;

    case (state)
      S_IDLE: begin
        if (det_valid) begin
          state_nxt = S_WAITING;
          kind_nxt  = det_kind;
          cnt_nxt   = wait_for(det_kind);
          addr_nxt  = A;
          wdata_nxt = D_in;
          nwait_nxt = 1'b0;
          if (det_kind == K_INTA) begin
            // The vector needs no backend round trip, so the ack is already satisfied.
            ack_seen_nxt = 1'b1;
            dout_nxt     = int_vector;
          end else begin
            ack_seen_nxt = 1'b0;
            req_nxt      = 1'b1;
            we_nxt       = (det_kind == K_MWR) || (det_kind == K_IOWR);
            io_nxt       = (det_kind == K_IORD) || (det_kind == K_IOWR);
          end
        end
      end

      S_WAITING: begin
        cnt_nxt = cnt_dec;
        if (mem_ack) begin
          ack_seen_nxt = 1'b1;
          if (kind_is_read) dout_nxt = mem_rdata;
        end
        if (bus_released) begin
          // CPU abandoned the cycle; an outstanding backend ack must still be absorbed.
          nwait_nxt = 1'b1;
          state_nxt = (ack_seen || mem_ack) ? S_IDLE : S_DRAIN;
        end else if ((ack_seen || mem_ack) && (cnt_dec == 4'd0)) begin
          nwait_nxt = 1'b1;
          state_nxt = S_HOLD;
          doe_nxt   = drives_bus && strobe_low;
        end
      end

      S_HOLD: begin
        if (bus_released) begin
          state_nxt = S_IDLE;
          doe_nxt   = 1'b0;
        end else begin
          doe_nxt = drives_bus && strobe_low;
        end
      end

      S_DRAIN: begin
        if (mem_ack) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      kind      <= K_MRD;
      cnt       <= 4'd0;
      ack_seen  <= 1'b0;
      nWAIT     <= 1'b1;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_io    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      kind      <= kind_nxt;
      cnt       <= cnt_nxt;
      ack_seen  <= ack_seen_nxt;
      nWAIT     <= nwait_nxt;
      D_out     <= dout_nxt;
      D_oe      <= doe_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_io    <= io_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: per-cycle vector table for the bus transactions,
// plus a hand-written asynchronous-reset sequence.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic        nWAIT;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  int_vector;
  logic        mem_req, mem_we, mem_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  z80_bus_responder #(
    .MEM_WAIT(2), .M1_WAIT(0), .IO_WAIT(1), .INTA_WAIT(0)
  ) dut (
    .clk(clk), .nreset(nreset),
    .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
    .A(A), .D_in(D_in), .nWAIT(nWAIT), .D_out(D_out), .D_oe(D_oe),
    .int_vector(int_vector),
    .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Strobe patterns, ordered {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH}.
  localparam logic [5:0] IDL = 6'b111111;
  localparam logic [5:0] MRD = 6'b101011;
  localparam logic [5:0] FET = 6'b001011;
  localparam logic [5:0] RFS = 6'b101110;
  localparam logic [5:0] IOW = 6'b110101;
  localparam logic [5:0] INA = 6'b010111;

  typedef struct {
    string       name;
    logic [5:0]  bus;
    logic [15:0] a;
    logic [7:0]  d;
    logic        ack;
    logic [7:0]  rdata;
    logic        e_nwait;
    logic        e_req;
    logic        e_we;
    logic        e_io;
    logic        e_oe;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [5:0] bus, input logic [15:0] a,
                              input logic [7:0] d, input logic ack, input logic [7:0] rdata,
                              input logic e_nwait, input logic e_req, input logic e_we,
                              input logic e_io, input logic e_oe, input logic [7:0] e_dout);
    vec_t v;
    v.name = name; v.bus = bus; v.a = a; v.d = d; v.ack = ack; v.rdata = rdata;
    v.e_nwait = e_nwait; v.e_req = e_req; v.e_we = e_we; v.e_io = e_io;
    v.e_oe = e_oe; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] bus, input logic [15:0] a, input logic [7:0] d,
                       input logic ack, input logic [7:0] rdata);
    {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH} = bus;
    A = a; D_in = d; mem_ack = ack; mem_rdata = rdata;
  endtask

  initial begin
    //            name        bus  addr      d      ack rdata  nw req we io oe dout
    vecs.push_back(mk("rd_idle",  IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("rd_det",   MRD, 16'h1234, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk("rd_w1",    MRD, 16'h1234, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("rd_ack",   MRD, 16'h1234, 8'h00, 1, 8'hA5, 1, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk("rd_hold",  MRD, 16'h1234, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'hA5));
    vecs.push_back(mk("rd_rel",   IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hA5));
    vecs.push_back(mk("fe_det",   FET, 16'h0100, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'hA5));
    vecs.push_back(mk("fe_ack",   FET, 16'h0100, 8'h00, 1, 8'h3E, 1, 0, 0, 0, 1, 8'h3E));
    vecs.push_back(mk("fe_rel",   IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("rf_1",     RFS, 16'h0042, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("rf_2",     RFS, 16'h0042, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("rf_end",   IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_det",  IOW, 16'h00FE, 8'h3C, 0, 8'h00, 0, 1, 1, 1, 0, 8'h3E));
    vecs.push_back(mk("iow_w1",   IOW, 16'h00FE, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_w2",   IOW, 16'h00FE, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_w3",   IOW, 16'h00FE, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_ack",  IOW, 16'h00FE, 8'h3C, 1, 8'h77, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_hold", IOW, 16'h00FE, 8'h3C, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("iow_rel",  IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h3E));
    vecs.push_back(mk("inta_det", INA, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("inta_w",   INA, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'hFF));
    vecs.push_back(mk("inta_hold",INA, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 8'hFF));
    vecs.push_back(mk("inta_rel", IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("ab_det",   MRD, 16'h2000, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("ab_w1",    MRD, 16'h2000, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("ab_rel",   IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("ab_drain", MRD, 16'h3000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("ab_ack",   IDL, 16'h0000, 8'h00, 1, 8'h55, 1, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("nx_det",   MRD, 16'h4000, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("nx_w1",    MRD, 16'h4000, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("nx_ack",   MRD, 16'h4000, 8'h00, 1, 8'h99, 1, 0, 0, 0, 1, 8'h99));
    vecs.push_back(mk("nx_rel",   IDL, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h99));

    nreset     = 1'b0;
    int_vector = 8'hFF;
    drive(IDL, 16'h0000, 8'h00, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_nwait", nWAIT, 1'b1);
    check("rst_oe",    D_oe, 1'b0);
    check("rst_dout",  D_out, 8'h00);
    check("rst_req",   mem_req, 1'b0);
    check("rst_we",    mem_we, 1'b0);
    check("rst_io",    mem_io, 1'b0);
    check("rst_addr",  mem_addr, 16'h0000);
    check("rst_wdata", mem_wdata, 8'h00);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.bus, v.a, v.d, v.ack, v.rdata);
      @(posedge clk);
      #1;
      check({v.name, ".nwait"}, nWAIT, v.e_nwait);
      check({v.name, ".req"},   mem_req, v.e_req);
      check({v.name, ".oe"},    D_oe, v.e_oe);
      check({v.name, ".dout"},  D_out, v.e_dout);
      if (v.e_req) begin
        check({v.name, ".we"},   mem_we, v.e_we);
        check({v.name, ".io"},   mem_io, v.e_io);
        check({v.name, ".addr"}, mem_addr, v.a);
        if (v.e_we) check({v.name, ".wdata"}, mem_wdata, v.d);
      end
    end

    // Reset pulsed in the middle of a read whose ack is still outstanding.
    drive(MRD, 16'h5000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("mr_req",  mem_req, 1'b1);
    check("mr_addr", mem_addr, 16'h5000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mr_wait", nWAIT, 1'b0);
    nreset = 1'b0;
    #1;
    check("mr_async_nwait", nWAIT, 1'b1);
    check("mr_async_oe",    D_oe, 1'b0);
    check("mr_async_req",   mem_req, 1'b0);
    check("mr_async_addr",  mem_addr, 16'h0000);
    check("mr_async_dout",  D_out, 8'h00);
    @(negedge clk);
    drive(IDL, 16'h0000, 8'h00, 1'b0, 8'h00);
    nreset = 1'b1;
    drive(IDL, 16'h0000, 8'h00, 1'b1, 8'hEE);
    @(posedge clk); #1;
    check("late_ack_nwait", nWAIT, 1'b1);
    check("late_ack_req",   mem_req, 1'b0);
    check("late_ack_dout",  D_out, 8'h00);
    check("late_ack_oe",    D_oe, 1'b0);

    // Read after reset; ack lands with mem_req but MEM_WAIT still holds nWAIT for 2 cycles.
    drive(MRD, 16'h6000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("pr_req",  mem_req, 1'b1);
    check("pr_addr", mem_addr, 16'h6000);
    check("pr_w0",   nWAIT, 1'b0);
    drive(MRD, 16'h6000, 8'h00, 1'b1, 8'hC3);
    @(posedge clk); #1;
    check("pr_w1",   nWAIT, 1'b0);
    drive(MRD, 16'h6000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("pr_done", nWAIT, 1'b1);
    check("pr_dout", D_out, 8'hC3);
    check("pr_oe",   D_oe, 1'b1);
    drive(IDL, 16'h0000, 8'h00, 1'b0, 8'h00);
    @(posedge clk); #1;
    check("pr_rel_oe", D_oe, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Synchronous external-device model and FPGA glue for the Z80 pin bus: the responding end of the CPU pin protocol.
- Decodes M1/MREQ/IORQ/RD/WR/RFSH strobes into memory, I/O and interrupt-acknowledge transactions.
- Forwards each transaction to a simple backend request/ack port and inserts wait states via nWAIT.
- Drives read and vector data onto the data bus.
- Sits outside the CPU core, between the CPU pin pads and system memory/peripherals; also used as the bench responder for CPU-level simulation.

Parameters:
MEM_WAIT, 0, minimum wait cycles for memory read/write (0..15)
M1_WAIT, 0, minimum wait cycles for opcode fetch (0..15)
IO_WAIT, 1, minimum wait cycles for I/O read/write (0..15)
INTA_WAIT, 0, minimum wait cycles for interrupt acknowledge (0..15)

Ports:
clk  in  1  CPU clock; all state on rising edge
nreset  in  1  asynchronous, active-low reset
nM1  in  1  CPU M1, active low
nMREQ  in  1  memory request, active low
nIORQ  in  1  I/O request, active low
nRD  in  1  read strobe, active low
nWR  in  1  write strobe, active low
nRFSH  in  1  refresh, active low
A  in  16  CPU address bus
D_in  in  8  CPU data bus (write data)
nWAIT  out  1  wait request to CPU, active low
D_out  out  8  data to CPU
D_oe  out  1  D_out drive enable
int_vector  in  8  byte returned on interrupt acknowledge
mem_req  out  1  backend request, one-cycle pulse
mem_we  out  1  backend write (valid with mem_req)
mem_io  out  1  backend I/O space (valid with mem_req)
mem_addr  out  16  backend address, held for the transaction
mem_wdata  out  8  backend write data, held for the transaction
mem_rdata  in  8  backend read data, valid with mem_ack
mem_ack  in  1  backend completion, one-cycle pulse; may be high in the mem_req cycle

Behaviour:
- Clock `clk`, reset `nreset`: one clock; reset is asynchronous and active-low.
- Reset values: nWAIT=1, D_oe=0, D_out=0, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_wdata=0, state IDLE, wait counter 0, ack_seen 0.
- States: IDLE, WAITING, HOLD, DRAIN.
- IDLE decode, sampled on rising edge, priority order:
  - nIORQ=0 & nM1=0 -> INTA.
  - nMREQ=0 & nRFSH=1 & nRD=0 -> MRD; kind FETCH if nM1=0.
  - nMREQ=0 & nRFSH=1 & nWR=0 -> MWR.
  - nIORQ=0 & nM1=1 & nRD=0 -> IORD.
  - nIORQ=0 & nM1=1 & nWR=0 -> IOWR.
  - nRFSH=0 cycles are ignored.
- On the detect edge:
  - Latch A -> mem_addr and D_in -> mem_wdata.
  - Load the counter with the kind's *_WAIT value (MEM_WAIT for MRD/MWR, M1_WAIT for FETCH, IO_WAIT for IORD/IOWR, INTA_WAIT for INTA).
  - nWAIT<=0.
  - For all kinds except INTA: mem_req<=1 for exactly one cycle, with mem_we = write kind and mem_io = I/O kind.
  - Go to WAITING.
- INTA issues no backend request: ack_seen is forced 1 and D_out<=int_vector.
- WAITING, each edge:
  - Counter decrements if nonzero.
  - ack_seen sets on mem_ack; on a read, D_out<=mem_rdata.
  - When ack_seen (or mem_ack this edge) and the counter after decrement is 0: nWAIT<=1, go to HOLD.
  - Resulting nWAIT-low duration is max(N, L, 1) cycles, where N = *_WAIT and L = edges from the mem_req edge to the ack edge (ack in the same cycle as mem_req counts as L=1).
  - The minimum of one wait cycle is intentional and documented.
- HOLD:
  - D_oe=1 for read kinds and INTA while the state is HOLD and the CPU strobe (nRD, or nIORQ for INTA) is sampled low.
  - Return to IDLE when nMREQ=1 and nIORQ=1 are sampled; D_oe<=0 on that edge.
  - No new decode on the release edge.
- Strobe released while in WAITING (bus aborted):
  - nWAIT<=1 and D_oe stays 0.
  - If the ack is still pending, go to DRAIN and wait for mem_ack, discarding its data; otherwise go to IDLE.
- D_out holds its last value outside HOLD.
- Reset asserted mid-transaction forces the reset values immediately. A mem_ack arriving after reset is ignored; the backend must tolerate an orphaned request.
- Counter is 4 bits; no wrap, saturates at 0.
- mem_ack in IDLE or HOLD is ignored.

Test Plan:
- MEM_WAIT=2, memory read A=0x1234, backend acks 1 cycle after mem_req with 0xA5 -> one mem_req pulse (we=0, io=0, addr 0x1234); nWAIT low exactly 2 cycles; D_out=0xA5 with D_oe=1 until nRD/nMREQ rise; back to IDLE.
- Opcode fetch, M1_WAIT=0, ack in the same cycle as mem_req -> nWAIT low exactly 1 cycle; the following refresh cycle (nRFSH=0, nMREQ=0) generates no mem_req.
- IO write A=0x00FE, D=0x3C, IO_WAIT=1, ack 4 cycles late -> mem_req with we=1, io=1, wdata 0x3C; nWAIT low 4 cycles; D_oe never asserted.
- INTA (nM1=0, nIORQ=0), int_vector=0xFF, INTA_WAIT=0 -> no mem_req; nWAIT low 1 cycle; D_out=0xFF driven while nIORQ=0.
- Read with ack delayed 6 cycles, nreset pulsed low at cycle 3 -> nWAIT=1, D_oe=0, mem_req=0 immediately; late ack ignored; next read decodes normally.
- Strobes released in WAITING before ack -> nWAIT=1 on the next edge, DRAIN until ack, no D_oe, then IDLE.
